// File: rtl/camera_pixel_axis_converter.sv
// RGB565 to 32-bit AXI4-Stream pixel converter that regenerates SOF/EOL from its own
// column/row counters, checks upstream framing and counts completed frames.
module camera_pixel_axis_converter #(
    parameter int unsigned FRAME_WIDTH  = 640,
    parameter int unsigned FRAME_HEIGHT = 480,
    parameter logic [7:0]  ALPHA        = 8'hFF
) (
    input  logic        axi_clk,
    input  logic        aresetn,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    input  logic [1:0]  mode,
    input  logic        err_clear,
    output logic        err_sof,
    output logic        err_eol,
    output logic [15:0] frame_count
);

    localparam int unsigned ColW = (FRAME_WIDTH > 2) ? $clog2(FRAME_WIDTH) : 1;
    localparam int unsigned RowW = (FRAME_HEIGHT > 2) ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [ColW-1:0] ColLast = ColW'(FRAME_WIDTH - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(FRAME_HEIGHT - 1);

    typedef enum logic {StWaitSof, StActive} state_e;

    state_e            state_q, state_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [RowW-1:0]   row_q, row_d;
    logic [1:0]        mode_q, mode_d;
    logic [31:0]       data_q, data_d;
    logic              valid_q, valid_d;
    logic              user_q, user_d;
    logic              last_q, last_d;
    logic              err_sof_q, err_sof_d;
    logic              err_eol_q, err_eol_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic              accept, emit;
    logic              at_origin, is_eol, is_last;
    logic              sof_set, eol_set;
    logic [ColW-1:0]   pos_col;
    logic [RowW-1:0]   pos_row;
    logic [1:0]        mode_eff;
    logic [7:0]        r8, g8, b8;
    logic [15:0]       y_sum;
    logic [31:0]       pix;

    assign s_axis_tready = (state_q == StWaitSof) | ~valid_q | m_axis_tready;
    assign accept        = s_axis_tvalid & s_axis_tready;
    // In WAIT_SOF only an SOF beat is emitted; everything else is dropped.
    assign emit          = accept & ((state_q == StActive) | s_axis_tuser);

    // An SOF beat always lands at (0,0), resynchronising a broken frame.
    assign at_origin = (col_q == '0) && (row_q == '0);
    assign pos_col   = s_axis_tuser ? '0 : col_q;
    assign pos_row   = s_axis_tuser ? '0 : row_q;
    assign is_eol    = (pos_col == ColLast);
    assign is_last   = is_eol && (pos_row == RowLast);
    assign mode_eff  = s_axis_tuser ? mode : mode_q;

    assign sof_set = emit & (state_q == StActive) & s_axis_tuser & ~at_origin;
    assign eol_set = emit & (state_q == StActive) & (s_axis_tlast != is_eol);

    assign r8    = {s_axis_tdata[15:11], s_axis_tdata[15:13]};
    assign g8    = {s_axis_tdata[10:5], s_axis_tdata[10:9]};
    assign b8    = {s_axis_tdata[4:0], s_axis_tdata[4:2]};
    assign y_sum = 16'd77 * 16'(r8) + 16'd150 * 16'(g8) + 16'd29 * 16'(b8);

    always_comb begin
        pix = '0;
        unique case (mode_eff)
            2'd0: pix = {r8, g8, b8, ALPHA};
            2'd1: pix = {b8, g8, r8, ALPHA};
            2'd2: pix = {y_sum[15:8], y_sum[15:8], y_sum[15:8], ALPHA};
            2'd3: pix = {16'h0000, s_axis_tdata};
            default: pix = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        mode_d      = mode_q;
        data_d      = data_q;
        valid_d     = valid_q;
        user_d      = user_q;
        last_d      = last_q;
        frame_cnt_d = frame_cnt_q;

        if (accept && s_axis_tuser) begin
            mode_d = mode;
        end

        if (emit) begin
            state_d = StActive;
            valid_d = 1'b1;
            data_d  = pix;
            user_d  = (pos_col == '0) && (pos_row == '0);
            last_d  = is_eol;
            if (is_eol) begin
                col_d = '0;
                row_d = is_last ? '0 : pos_row + RowW'(1);
                if (is_last) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end else begin
                col_d = pos_col + ColW'(1);
                row_d = pos_row;
            end
        end else if (m_axis_tready) begin
            valid_d = 1'b0;
        end

        // A new error in the same cycle as err_clear stays set.
        err_sof_d = sof_set | (err_sof_q & ~err_clear);
        err_eol_d = eol_set | (err_eol_q & ~err_clear);
    end

    always_ff @(posedge axi_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StWaitSof;
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= 2'd0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            user_q      <= 1'b0;
            last_q      <= 1'b0;
            err_sof_q   <= 1'b0;
            err_eol_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            mode_q      <= mode_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            user_q      <= user_d;
            last_q      <= last_d;
            err_sof_q   <= err_sof_d;
            err_eol_q   <= err_eol_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tuser  = user_q;
    assign m_axis_tlast  = last_q;
    assign err_sof       = err_sof_q;
    assign err_eol       = err_eol_q;
    assign frame_count   = frame_cnt_q;

endmodule

// File: tb/tb_camera_pixel_axis_converter.sv
// Bench for camera_pixel_axis_converter: a frame-index model predicts every output beat,
// ready/valid and status each cycle; directed frames pin formats, framing and reset.
module tb_camera_pixel_axis_converter;

    localparam int W = 8;
    localparam int H = 4;
    localparam logic [7:0] ALPHA = 8'hFF;

    logic        axi_clk;
    logic        aresetn;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tuser;
    logic        s_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic [1:0]  mode;
    logic        err_clear;
    logic        err_sof;
    logic        err_eol;
    logic [15:0] frame_count;

    camera_pixel_axis_converter #(
        .FRAME_WIDTH (W),
        .FRAME_HEIGHT(H),
        .ALPHA       (ALPHA)
    ) dut (
        .axi_clk      (axi_clk),
        .aresetn      (aresetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .mode         (mode),
        .err_clear    (err_clear),
        .err_sof      (err_sof),
        .err_eol      (err_eol),
        .frame_count  (frame_count)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] conv(input logic [15:0] d, input logic [1:0] md);
        int r, g, b, y;
        r = int'(d[15:11]);
        g = int'(d[10:5]);
        b = int'(d[4:0]);
        r = r * 8 + r / 4;
        g = g * 4 + g / 16;
        b = b * 8 + b / 4;
        y = (77 * r + 150 * g + 29 * b) / 256;
        case (md)
            2'd0:    return {r[7:0], g[7:0], b[7:0], ALPHA};
            2'd1:    return {b[7:0], g[7:0], r[7:0], ALPHA};
            2'd2:    return {y[7:0], y[7:0], y[7:0], ALPHA};
            default: return {16'h0000, d};
        endcase
    endfunction

    // Model: position within the frame as a flat pixel index.
    bit          m_active;
    int          m_idx;
    int          m_fc;
    logic [1:0]  m_mode;
    bit          m_err_sof, m_err_eol;
    bit          exp_mvalid;
    logic [33:0] exp_q[$];
    logic [31:0] out_log[$];
    bit          user_log[$];
    bit          last_log[$];
    int          n_out, n_user, n_last;

    always @(negedge axi_clk) begin
        if (!aresetn) begin
            m_active = 0; m_idx = 0; m_fc = 0; m_mode = 2'd0;
            m_err_sof = 0; m_err_eol = 0; exp_mvalid = 0;
            exp_q.delete();
            chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
            chk("rst_tdata", m_axis_tdata, 32'd0);
            chk("rst_tuser_tlast", {30'd0, m_axis_tuser, m_axis_tlast}, 32'd0);
        end else begin
            bit acc, new_sof, new_eol, exp_ready;
            int col;
            logic [33:0] e;
            exp_ready = !m_active || !exp_mvalid || m_axis_tready;
            chk("m_tvalid", 32'(m_axis_tvalid), 32'(exp_mvalid));
            chk("s_tready", 32'(s_axis_tready), 32'(exp_ready));
            chk("err_sof", 32'(err_sof), 32'(m_err_sof));
            chk("err_eol", 32'(err_eol), 32'(m_err_eol));
            chk("frame_count", 32'(frame_count), 32'(m_fc));
            if (m_axis_tvalid && m_axis_tready) begin
                chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("m_tdata", m_axis_tdata, e[33:2]);
                    chk("m_tuser", 32'(m_axis_tuser), 32'(e[1]));
                    chk("m_tlast", 32'(m_axis_tlast), 32'(e[0]));
                end
                out_log.push_back(m_axis_tdata);
                user_log.push_back(m_axis_tuser);
                last_log.push_back(m_axis_tlast);
                n_out++;
                if (m_axis_tuser) n_user++;
                if (m_axis_tlast) n_last++;
            end
            acc = s_axis_tvalid && exp_ready;
            new_sof = 0; new_eol = 0;
            if (acc && (m_active || s_axis_tuser)) begin
                if (s_axis_tuser) begin
                    if (m_active && m_idx != 0) new_sof = 1;
                    m_idx  = 0;
                    m_mode = mode;
                end
                col = m_idx % W;
                if (m_active && (s_axis_tlast != (col == W - 1))) new_eol = 1;
                exp_q.push_back({conv(s_axis_tdata, m_mode), m_idx == 0, col == W - 1});
                m_idx++;
                if (m_idx == W * H) begin
                    m_idx = 0;
                    m_fc  = (m_fc + 1) % 65536;
                end
                m_active   = 1;
                exp_mvalid = 1;
            end else if (m_axis_tready) begin
                exp_mvalid = 0;
            end
            m_err_sof = new_sof || (m_err_sof && !err_clear);
            m_err_eol = new_eol || (m_err_eol && !err_clear);
        end
    end

    bit bp_en = 0;
    int cyc   = 0;
    always @(posedge axi_clk) begin
        #1;
        cyc++;
        m_axis_tready = !(bp_en && (cyc % 3 == 0));
    end

    logic [15:0] frame_px[W*H];

    task automatic fill(input int seed, input logic [15:0] v, input bit constant);
        for (int i = 0; i < W * H; i++) frame_px[i] = constant ? v : 16'(seed * 4099 + i * 1237 + 99);
    endtask

    task automatic send_beat(input logic [15:0] d, input logic u, input logic l,
                             input logic [1:0] md);
        int n;
        n = 0;
        s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; mode = md;
        s_axis_tvalid = 1'b1;
        forever begin
            @(negedge axi_clk);
            if (s_axis_tready) break;
            n++;
            if (n > 200) begin
                chk("input_accept_timeout", 32'(n), 32'd0);
                break;
            end
        end
        @(posedge axi_clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [1:0] md0, input logic [1:0] mdr,
                              input int bad_col);
        for (int i = 0; i < n; i++)
            send_beat(frame_px[i], i == 0, (i % W == W - 1) || (i < W && i == bad_col),
                      (i == 0) ? md0 : mdr);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !m_axis_tvalid) break;
            @(posedge axi_clk);
            #2;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    int b, nb, nu, nl;
    logic [31:0] clean_log[$];
    int diffs;

    initial begin
        aresetn = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0;
        s_axis_tlast = 1'b0; mode = 2'd0; err_clear = 1'b0;
        repeat (3) @(posedge axi_clk);
        #1 aresetn = 1'b1;
        @(negedge axi_clk);
        chk("reset_s_tready", 32'(s_axis_tready), 32'd1);
        chk("reset_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("reset_frame_count", 32'(frame_count), 32'd0);
        chk("reset_errs", {30'd0, err_sof, err_eol}, 32'd0);
        @(posedge axi_clk);
        #1;

        // Leading garbage then one frame per format.
        b = out_log.size(); nb = n_out;
        for (int i = 0; i < 5; i++) send_beat(16'hABC0 + 16'(i), 1'b0, 1'b0, 2'd1);
        fill(1, 0, 0); frame_px[0] = 16'hF800; frame_px[1] = 16'h07E0; frame_px[2] = 16'h001F;
        send_frame(W * H, 2'd0, 2'd0, -1);
        drain();
        chk("garbage_frame_beats", 32'(n_out - nb), 32'd32);
        fill(2, 0, 0); frame_px[0] = 16'hF800;
        send_frame(W * H, 2'd1, 2'd1, -1);
        fill(3, 0, 0); frame_px[0] = 16'hFFFF; frame_px[1] = 16'h0000;
        send_frame(W * H, 2'd2, 2'd2, -1);
        fill(4, 0, 0); frame_px[0] = 16'h1234;
        send_frame(W * H, 2'd3, 2'd3, -1);
        drain();
        chk("fmt0_red", out_log[b + 0], 32'hFF0000FF);
        chk("fmt0_green", out_log[b + 1], 32'h00FF00FF);
        chk("fmt0_blue", out_log[b + 2], 32'h0000FFFF);
        chk("fmt1_red", out_log[b + 32], 32'h0000FFFF);
        chk("fmt2_white", out_log[b + 64], 32'hFFFFFFFF);
        chk("fmt2_black", out_log[b + 65], 32'h000000FF);
        chk("fmt3_raw", out_log[b + 96], 32'h00001234);
        chk("fc_after_formats", 32'(frame_count), 32'd4);

        // Clean stream of 10 frames.
        b = out_log.size(); nb = n_out; nu = n_user; nl = n_last;
        for (int f = 0; f < 10; f++) begin
            fill(10 + f, 0, 0);
            send_frame(W * H, 2'(f % 3), 2'(f % 3), -1);
        end
        drain();
        chk("clean_beats", 32'(n_out - nb), 32'd320);
        chk("clean_tuser", 32'(n_user - nu), 32'd10);
        chk("clean_tlast", 32'(n_last - nl), 32'd40);
        chk("clean_fc", 32'(frame_count), 32'd14);
        chk("clean_errs", {30'd0, err_sof, err_eol}, 32'd0);
        for (int i = 0; i < 320; i++) clean_log.push_back(out_log[b + i]);

        // Same frames with 1-in-3 backpressure.
        bp_en = 1;
        b = out_log.size(); nb = n_out;
        for (int f = 0; f < 10; f++) begin
            fill(10 + f, 0, 0);
            send_frame(W * H, 2'(f % 3), 2'(f % 3), -1);
        end
        drain();
        bp_en = 0;
        chk("bp_beats", 32'(n_out - nb), 32'd320);
        diffs = 0;
        for (int i = 0; i < 320; i++) if (out_log[b + i] !== clean_log[i]) diffs++;
        chk("bp_sequence_diffs", 32'(diffs), 32'd0);
        chk("bp_fc", 32'(frame_count), 32'd24);

        // Early SOF at line 1 pixel 3, then a frame with a stray TLAST on column 5.
        b = out_log.size();
        fill(30, 0, 0);
        send_frame(W + 3, 2'd0, 2'd0, -1);
        fill(31, 0, 0);
        send_frame(W * H, 2'd0, 2'd0, 5);
        drain();
        chk("err_sof_set", 32'(err_sof), 32'd1);
        chk("err_eol_set", 32'(err_eol), 32'd1);
        chk("resync_tuser", 32'(user_log[b + W + 3]), 32'd1);
        chk("stray_col5_tlast", 32'(last_log[b + W + 3 + 5]), 32'd0);
        chk("col7_tlast", 32'(last_log[b + W + 3 + 7]), 32'd1);
        chk("interrupted_not_counted", 32'(frame_count), 32'd25);
        err_clear = 1'b1;
        @(posedge axi_clk);
        #1 err_clear = 1'b0;
        @(negedge axi_clk);
        chk("errs_cleared", {30'd0, err_sof, err_eol}, 32'd0);
        @(posedge axi_clk);
        #1;

        // Mode changed mid-frame only takes effect at the next SOF.
        b = out_log.size();
        fill(0, 16'hF800, 1);
        send_frame(W * H, 2'd0, 2'd2, -1);
        send_frame(W * H, 2'd2, 2'd2, -1);
        drain();
        chk("mode_held_midframe", out_log[b + 5], 32'hFF0000FF);
        chk("mode_new_at_sof", out_log[b + 32], 32'h4C4C4CFF);
        chk("fc_after_mode", 32'(frame_count), 32'd27);

        // Reset mid-frame with an output beat pending.
        fill(40, 0, 0);
        send_frame(10, 2'd1, 2'd1, -1);
        chk("pre_reset_tvalid", 32'(m_axis_tvalid), 32'd1);
        aresetn = 1'b0;
        #1;
        chk("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("midrst_tdata", m_axis_tdata, 32'd0);
        chk("midrst_flags", {28'd0, m_axis_tuser, m_axis_tlast, err_sof, err_eol}, 32'd0);
        chk("midrst_fc", 32'(frame_count), 32'd0);
        repeat (2) @(posedge axi_clk);
        #1 aresetn = 1'b1;
        b = out_log.size(); nb = n_out;
        fill(41, 0, 0);
        send_frame(W * H, 2'd0, 2'd0, -1);
        drain();
        chk("post_reset_beats", 32'(n_out - nb), 32'd32);
        chk("post_reset_sof", 32'(user_log[b]), 32'd1);
        chk("post_reset_fc", 32'(frame_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
